pcd_frame_pingpong: RTL and testbench
=====================================

Name: pcd_frame_pingpong

Overview:
- Parametrised ping-pong frame buffer placed in front of the PCD decode core.
- Captures one frame of FRAME_LEN soft symbols per frame_start into one of two banks.
- While that bank is being filled, it streams the other completed bank to the decoder over a valid/ready interface.
- Generalises the fixed 8-bit / 8640-symbol, single-frame PCD input path: adds a configurable width and length, back-pressure, overlapped frames, and overflow and abort handling.

Parameters:
- SYM_W, 8: soft-symbol width in bits.
- FRAME_LEN, 8640: symbols per frame; must be at least 2.
- ADDR_W, 14: bank address width; requires 2^ADDR_W >= FRAME_LEN.

Ports:
- clk_in, input, 1: single clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- symbol_din, input, SYM_W: input soft symbol.
- din_valid, input, 1: symbol_din is valid this cycle.
- frame_start, input, 1: one-cycle pulse that must coincide with the first valid symbol of a frame.
- dout, output, SYM_W: symbol presented to the decoder.
- dout_valid, output, 1: dout is valid.
- dout_ready, input, 1: decoder accepts dout; a transfer occurs when dout_valid and dout_ready are both high.
- dout_last, output, 1: dout is symbol FRAME_LEN-1 of the frame.
- frame_finish, output, 1: one-cycle pulse on the cycle after the last transfer of a frame.
- frame_drop, output, 1: one-cycle pulse when an incoming frame is discarded.
- frame_abort, output, 1: one-cycle pulse when a partial frame is abandoned.
- bank_full, output, 2: bit b is high while bank b holds an unread or partially read frame.

Behaviour:
- Reset is synchronous (reset high at a rising edge):
  - all outputs go to 0;
  - both banks are marked empty;
  - write pointer wbank=0, read pointer rbank=0;
  - write FSM goes to W_IDLE, read FSM goes to R_IDLE.
- Reset mid-frame discards all buffered data. No frame_finish, frame_drop or frame_abort pulse is produced by reset.
- Write FSM:
  - W_IDLE: on frame_start & din_valid:
    - if bank_full[wbank]=0: write the symbol at address 0, set wcnt=1, go to W_FILL;
    - otherwise: pulse frame_drop, go to W_DROP.
  - W_FILL: each din_valid writes symbol_din at address wcnt and increments wcnt.
    - The write with wcnt=FRAME_LEN-1 sets bank_full[wbank], toggles wbank and returns to W_IDLE.
  - W_DROP: ignores symbols until FRAME_LEN-1 further valid symbols have been counted, then returns to W_IDLE. A frame_start seen in this state is handled as in W_FILL.
  - frame_start & din_valid while in W_FILL or W_DROP:
    - pulse frame_abort;
    - the partial bank stays empty;
    - the new frame restarts at address 0 of the same wbank, subject to the same full check.
  - din_valid without frame_start in W_IDLE is ignored.
  - frame_start without din_valid is ignored.
- Read FSM:
  - R_IDLE: when bank_full[rbank]=1, issue the read of address 0 and go to R_PREF.
  - R_PREF: RAM read latency is 1 cycle. Load the output register, assert dout_valid, go to R_STREAM.
  - R_STREAM: dout and dout_valid hold stable while dout_ready=0. On each transfer the next symbol appears in the following cycle with no bubble; prefetch is used so full throughput is 1 symbol per cycle.
  - dout_last is high with symbol FRAME_LEN-1.
  - On the last transfer:
    - deassert dout_valid next cycle;
    - pulse frame_finish next cycle;
    - clear bank_full[rbank];
    - toggle rbank;
    - return to R_IDLE.
- Latency: the first dout_valid occurs 2 cycles after the clock edge that writes the last symbol, when the read side is idle.
- A bank that is cleared and refilled in the same cycle: the clear wins for that bank, and the write FSM sees it as empty on the next frame_start.
- Back-to-back frames with dout_ready held high never drop.
- Counters are ADDR_W bits wide and compared against FRAME_LEN-1; there is no wrap beyond FRAME_LEN.
- Both banks together form 2*FRAME_LEN x SYM_W of inferred RAM with one write port and one read port.

Optional Feature:
- Macro: PCD_FRAME_STATS_EN.
- Defined: adds output frames_done [15:0], which increments on each frame_finish, and output frames_dropped [15:0], which increments on each frame_drop or frame_abort.
  - Both counters saturate at 16'hFFFF.
  - Both counters clear on reset.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Single frame, FRAME_LEN=16, SYM_W=8, dout_ready=1, symbols 0..15:
  - dout sequence is 0..15;
  - first dout_valid 2 cycles after the last write;
  - dout_last with value 15;
  - frame_finish one cycle later;
  - bank_full returns to 00.
- Three back-to-back frames (values 0..47), dout_ready=1: output is exactly 0..47 in order, no frame_drop, bank_full toggles 01/10.
- Back-pressure with dout_ready toggling 1,0,1,0: dout holds its value while ready=0, every symbol is delivered exactly once, frame_finish count is 1.
- dout_ready=0 while three frames arrive:
  - frames 1 and 2 fill, bank_full=11;
  - frame 3 start pulses frame_drop;
  - after releasing ready, only frames 1 and 2 appear.
- frame_start again after 5 symbols:
  - frame_abort pulses;
  - the subsequent full frame is output intact with no residue from the aborted 5 symbols.
- Reset asserted mid-stream in R_STREAM: next cycle dout_valid=0 and bank_full=00; a new frame after reset is output correctly. With PCD_FRAME_STATS_EN defined, frames_done and frames_dropped read 0 after reset.

Source files
------------

// File: rtl/pcd_frame_pingpong.sv
// Ping-pong frame buffer in front of the PCD decoder: one bank fills while the other streams out.
// Optional frame statistics outputs are compiled in with `define PCD_FRAME_STATS_EN.
module pcd_frame_pingpong #(
  parameter int SYM_W     = 8,
  parameter int FRAME_LEN = 8640,
  parameter int ADDR_W    = 14
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [SYM_W-1:0] symbol_din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [SYM_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             frame_finish,
  output logic             frame_drop,
  output logic             frame_abort,
  output logic [1:0]       bank_full
`ifdef PCD_FRAME_STATS_EN
  ,
  output logic [15:0]      frames_done,
  output logic [15:0]      frames_dropped
`endif
);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_FILL   = 2'd1;
  localparam logic [1:0] W_DROP   = 2'd2;
  localparam logic [1:0] R_IDLE   = 2'd0;
  localparam logic [1:0] R_PREF   = 2'd1;
  localparam logic [1:0] R_STREAM = 2'd2;

  localparam int IDX_W  = ADDR_W + 1;
  localparam int DEPTH  = 2 * FRAME_LEN;
  localparam int MEM_AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  // Bank b occupies entries [b*FRAME_LEN, b*FRAME_LEN + FRAME_LEN - 1].
  function automatic logic [MEM_AW-1:0] mem_index(input logic bank, input logic [ADDR_W-1:0] a);
    logic [IDX_W-1:0] idx;
    idx = bank ? (IDX_W'(FRAME_LEN) + {1'b0, a}) : {1'b0, a};
    return MEM_AW'(idx);
  endfunction

  logic [SYM_W-1:0]  mem [0:DEPTH-1];
  logic [SYM_W-1:0]  rd_data;

  logic [1:0]        w_state;
  logic [ADDR_W-1:0] wcnt;
  logic              wbank;
  logic [1:0]        r_state;
  logic [ADDR_W-1:0] dcnt;
  logic [ADDR_W-1:0] dnext;
  logic              rbank;

  logic              start;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              wr_last;
  logic              rd_en;
  logic [ADDR_W-1:0] raddr;
  logic              xfer;
  logic              rd_done;
  logic [1:0]        set_full;
  logic [1:0]        clr_full;

  assign start = frame_start & din_valid;

  // Output handshake: a symbol moves when dout_valid and dout_ready are both high at a
  // rising edge; while dout_valid is high and dout_ready low, dout/dout_last hold stable.
  assign xfer    = dout_valid & dout_ready;
  assign dnext   = dcnt + ADDR_W'(1);
  assign wr_last = din_valid & ~start & (w_state == W_FILL) & (wcnt == LAST_ADDR);
  assign rd_done = (r_state == R_STREAM) & xfer & dout_last;

  always_comb begin
    we    = 1'b0;
    waddr = wcnt;
    if (start && !bank_full[wbank]) begin
      we    = 1'b1;
      waddr = '0;
    end else if (!start && din_valid && w_state == W_FILL) begin
      we = 1'b1;
    end
  end

  always_comb begin
    set_full = 2'b00;
    clr_full = 2'b00;
    if (wr_last) set_full[wbank] = 1'b1;
    if (rd_done) clr_full[rbank] = 1'b1;
  end

  // The read side runs one address ahead of dout so a transfer every cycle never bubbles.
  always_comb begin
    rd_en = 1'b0;
    raddr = '0;
    case (r_state)
      R_IDLE: begin
        rd_en = bank_full[rbank];
        raddr = '0;
      end
      R_PREF: begin
        rd_en = 1'b1;
        raddr = ADDR_W'(1);
      end
      R_STREAM: begin
        rd_en = xfer & ~dout_last & (dnext != LAST_ADDR);
        raddr = dcnt + ADDR_W'(2);
      end
      default: begin
        rd_en = 1'b0;
        raddr = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (we) mem[mem_index(wbank, waddr)] <= symbol_din;
  end

  always_ff @(posedge clk_in) begin
    if (rd_en) rd_data <= mem[mem_index(rbank, raddr)];
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      w_state     <= W_IDLE;
      wcnt        <= '0;
      wbank       <= 1'b0;
      frame_drop  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_drop  <= 1'b0;
      frame_abort <= 1'b0;
      if (start) begin
        // A new frame always restarts at address 0 of the current write bank.
        if (w_state != W_IDLE) frame_abort <= 1'b1;
        wcnt <= ADDR_W'(1);
        if (bank_full[wbank]) begin
          frame_drop <= 1'b1;
          w_state    <= W_DROP;
        end else begin
          w_state <= W_FILL;
        end
      end else if (din_valid && w_state != W_IDLE) begin
        if (wcnt == LAST_ADDR) begin
          w_state <= W_IDLE;
          if (w_state == W_FILL) wbank <= ~wbank;
        end else begin
          wcnt <= wcnt + ADDR_W'(1);
        end
      end
    end
  end

  // Banks cannot be set and cleared together in practice; if they were, the clear wins.
  always_ff @(posedge clk_in) begin
    if (reset) bank_full <= 2'b00;
    else       bank_full <= (bank_full | set_full) & ~clr_full;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state      <= R_IDLE;
      rbank        <= 1'b0;
      dcnt         <= '0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      dout_last    <= 1'b0;
      frame_finish <= 1'b0;
    end else begin
      frame_finish <= 1'b0;
      case (r_state)
        R_IDLE: begin
          if (bank_full[rbank]) r_state <= R_PREF;
        end
        R_PREF: begin
          dout       <= rd_data;
          dout_valid <= 1'b1;
          dout_last  <= 1'b0;
          dcnt       <= '0;
          r_state    <= R_STREAM;
        end
        R_STREAM: begin
          if (xfer) begin
            if (dout_last) begin
              dout_valid   <= 1'b0;
              dout_last    <= 1'b0;
              frame_finish <= 1'b1;
              rbank        <= ~rbank;
              r_state      <= R_IDLE;
            end else begin
              dout      <= rd_data;
              dout_last <= (dnext == LAST_ADDR);
              dcnt      <= dnext;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef PCD_FRAME_STATS_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, frames_dropped} + 17'(frame_drop) + 17'(frame_abort);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      frames_done    <= '0;
      frames_dropped <= '0;
    end else begin
      if (frame_finish && frames_done != 16'hFFFF) frames_done <= frames_done + 16'd1;
      frames_dropped <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_pcd_frame_pingpong.sv
// Bench for pcd_frame_pingpong: scenario tasks drive frames, a negedge monitor scores the output stream.
module tb_pcd_frame_pingpong;
  localparam int SYM_W     = 8;
  localparam int FRAME_LEN = 16;
  localparam int ADDR_W    = 4;

  logic             clk;
  logic             reset;
  logic [SYM_W-1:0] symbol_din;
  logic             din_valid;
  logic             frame_start;
  logic [SYM_W-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_last;
  logic             frame_finish;
  logic             frame_drop;
  logic             frame_abort;
  logic [1:0]       bank_full;
`ifdef PCD_FRAME_STATS_EN
  logic [15:0]      frames_done;
  logic [15:0]      frames_dropped;
`endif

  pcd_frame_pingpong #(.SYM_W(SYM_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
    .clk_in(clk), .reset(reset), .symbol_din(symbol_din), .din_valid(din_valid),
    .frame_start(frame_start), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_last(dout_last), .frame_finish(frame_finish), .frame_drop(frame_drop),
    .frame_abort(frame_abort), .bank_full(bank_full)
`ifdef PCD_FRAME_STATS_EN
    , .frames_done(frames_done), .frames_dropped(frames_dropped)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [SYM_W:0] exp_q[$];
  logic [SYM_W:0] exp_v;

  int finish_cnt = 0, drop_cnt = 0, abort_cnt = 0, stall_cnt = 0;
  int last_write_cyc = 0, first_valid_cyc = 0;
  bit seen_valid = 0, seen01 = 0, seen10 = 0, seen11 = 0;
  bit prev_stall = 0, last_pend = 0;
  logic [SYM_W-1:0] prev_dout = '0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (frame_finish === 1'b1) finish_cnt++;
    if (frame_drop === 1'b1)   drop_cnt++;
    if (frame_abort === 1'b1)  abort_cnt++;
    if (reset !== 1'b0) begin
      prev_stall = 0;
      last_pend  = 0;
    end else begin
      checks++;
      if (frame_finish !== last_pend) begin
        errors++;
        $display("FAIL finish_timing: frame_finish=%b expected %b at cycle %0d", frame_finish, last_pend, cyc);
      end
      if (last_pend) begin
        checks++;
        if (dout_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_after_last: dout_valid=%b expected 0 at cycle %0d", dout_valid, cyc);
        end
      end
      if (prev_stall) begin
        checks++;
        if (dout_valid !== 1'b1 || dout !== prev_dout) begin
          errors++;
          $display("FAIL hold: dout_valid=%b dout=%0h expected 1/%0h at cycle %0d", dout_valid, dout, prev_dout, cyc);
        end
      end
      if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer: dout=%0h last=%b expected no transfer", dout, dout_last);
        end else begin
          exp_v = exp_q.pop_front();
          if ({dout_last, dout} !== exp_v) begin
            errors++;
            $display("FAIL data: last/dout=%b/%0h expected %b/%0h", dout_last, dout, exp_v[SYM_W], exp_v[SYM_W-1:0]);
          end
        end
        last_pend = dout_last;
      end else begin
        last_pend = 0;
      end
      prev_stall = (dout_valid === 1'b1) && (dout_ready === 1'b0);
      if (prev_stall) stall_cnt++;
      prev_dout = dout;
      if (dout_valid === 1'b1 && !seen_valid) begin
        seen_valid      = 1;
        first_valid_cyc = cyc;
      end
      if (bank_full === 2'b01) seen01 = 1;
      if (bank_full === 2'b10) seen10 = 1;
      if (bank_full === 2'b11) seen11 = 1;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      din_valid   = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic send_frame(input int base, input int n, input bit push, input int gap_max);
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) begin
        int k;
        k = $urandom_range(0, gap_max);
        for (int j = 0; j < k; j++) begin
          @(posedge clk); #1;
          din_valid   = 1'b0;
          frame_start = 1'($urandom_range(0, 1));
          symbol_din  = SYM_W'($urandom);
        end
      end
      @(posedge clk); #1;
      din_valid   = 1'b1;
      frame_start = (i == 0);
      symbol_din  = SYM_W'(base + i);
      if (push) exp_q.push_back({(i == n - 1), SYM_W'(base + i)});
      if (i == n - 1) last_write_cyc = cyc + 1;
    end
    @(posedge clk); #1;
    din_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || dout_valid !== 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s_drain: %0d symbols still pending after 400 cycles, expected 0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (dout_valid !== 1'b0)   begin errors++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
    if (dout !== '0)           begin errors++; $display("FAIL reset_dout: got %0h expected 0", dout); end
    if (dout_last !== 1'b0)    begin errors++; $display("FAIL reset_dout_last: got %b expected 0", dout_last); end
    if (frame_finish !== 1'b0) begin errors++; $display("FAIL reset_finish: got %b expected 0", frame_finish); end
    if (frame_drop !== 1'b0)   begin errors++; $display("FAIL reset_drop: got %b expected 0", frame_drop); end
    if (frame_abort !== 1'b0)  begin errors++; $display("FAIL reset_abort: got %b expected 0", frame_abort); end
    if (bank_full !== 2'b00)   begin errors++; $display("FAIL reset_bank_full: got %b expected 00", bank_full); end
`ifdef PCD_FRAME_STATS_EN
    checks += 2;
    if (frames_done !== 16'd0)    begin errors++; $display("FAIL reset_frames_done: got %0d expected 0", frames_done); end
    if (frames_dropped !== 16'd0) begin errors++; $display("FAIL reset_frames_dropped: got %0d expected 0", frames_dropped); end
`endif
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int f0;
    f0 = finish_cnt;
    dout_ready = 1'b1;
    seen_valid = 0;
    send_frame(0, FRAME_LEN, 1, 0);
    wait_drain("single");
    checks += 3;
    if (first_valid_cyc - last_write_cyc !== 2) begin
      errors++;
      $display("FAIL single_latency: first valid %0d cycles after last write, expected 2", first_valid_cyc - last_write_cyc);
    end
    if (finish_cnt - f0 !== 1) begin errors++; $display("FAIL single_finish_count: got %0d expected 1", finish_cnt - f0); end
    if (bank_full !== 2'b00)   begin errors++; $display("FAIL single_bank_full: got %b expected 00", bank_full); end
  endtask

  task automatic test_back_to_back();
    int f0, d0;
    f0 = finish_cnt; d0 = drop_cnt;
    seen01 = 0; seen10 = 0; seen11 = 0;
    dout_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(f * FRAME_LEN, FRAME_LEN, 1, 0);
      idle(3);
    end
    wait_drain("b2b");
    checks += 5;
    if (drop_cnt - d0 !== 0)   begin errors++; $display("FAIL b2b_drop: got %0d drops expected 0", drop_cnt - d0); end
    if (finish_cnt - f0 !== 3) begin errors++; $display("FAIL b2b_finish_count: got %0d expected 3", finish_cnt - f0); end
    if (seen11 !== 1'b0)       begin errors++; $display("FAIL b2b_bank_11: seen=%b expected 0", seen11); end
    if (seen01 !== 1'b1)       begin errors++; $display("FAIL b2b_bank_01: seen=%b expected 1", seen01); end
    if (seen10 !== 1'b1)       begin errors++; $display("FAIL b2b_bank_10: seen=%b expected 1", seen10); end
  endtask

  task automatic test_backpressure();
    int f0, s0;
    f0 = finish_cnt; s0 = stall_cnt;
    fork
      send_frame(80, FRAME_LEN, 1, 1);
      begin
        for (int i = 0; i < 90; i++) begin
          @(posedge clk); #1;
          dout_ready = (i % 2 == 0);
        end
        dout_ready = 1'b1;
      end
    join
    wait_drain("bp");
    checks += 2;
    if (finish_cnt - f0 !== 1) begin errors++; $display("FAIL bp_finish_count: got %0d expected 1", finish_cnt - f0); end
    if (stall_cnt - s0 <= 0)   begin errors++; $display("FAIL bp_stalls: got %0d stall cycles expected >0", stall_cnt - s0); end
  endtask

  task automatic test_drop();
    int f0, d0, a0;
    f0 = finish_cnt; d0 = drop_cnt; a0 = abort_cnt;
    dout_ready = 1'b0;
    send_frame(100, FRAME_LEN, 1, 2);
    send_frame(120, FRAME_LEN, 1, 2);
    @(negedge clk);
    checks++;
    if (bank_full !== 2'b11) begin errors++; $display("FAIL drop_bank_full_11: got %b expected 11", bank_full); end
    send_frame(140, FRAME_LEN, 0, 1);
    idle(2);
    @(negedge clk);
    checks += 3;
    if (drop_cnt - d0 !== 1)  begin errors++; $display("FAIL drop_count: got %0d expected 1", drop_cnt - d0); end
    if (abort_cnt - a0 !== 0) begin errors++; $display("FAIL drop_abort: got %0d expected 0", abort_cnt - a0); end
    if (bank_full !== 2'b11)  begin errors++; $display("FAIL drop_bank_full_hold: got %b expected 11", bank_full); end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    wait_drain("drop");
    checks += 2;
    if (finish_cnt - f0 !== 2) begin errors++; $display("FAIL drop_finish_count: got %0d expected 2", finish_cnt - f0); end
    if (bank_full !== 2'b00)   begin errors++; $display("FAIL drop_bank_full_end: got %b expected 00", bank_full); end
  endtask

  task automatic test_abort();
    int f0, d0, a0;
    f0 = finish_cnt; d0 = drop_cnt; a0 = abort_cnt;
    dout_ready = 1'b1;
    send_frame(200, 5, 0, 0);
    send_frame(50, FRAME_LEN, 1, 2);
    wait_drain("abort");
    checks += 3;
    if (abort_cnt - a0 !== 1)  begin errors++; $display("FAIL abort_count: got %0d expected 1", abort_cnt - a0); end
    if (drop_cnt - d0 !== 0)   begin errors++; $display("FAIL abort_drop: got %0d expected 0", drop_cnt - d0); end
    if (finish_cnt - f0 !== 1) begin errors++; $display("FAIL abort_finish_count: got %0d expected 1", finish_cnt - f0); end
  endtask

  task automatic test_reset_mid_stream();
    int f0, d0, a0, n;
    dout_ready = 1'b1;
    send_frame(30, FRAME_LEN, 1, 0);
    n = 0;
    while (exp_q.size() > 8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL rst_mid_reach_stream: %0d pending after 100 cycles, expected <=8", exp_q.size()); end
    f0 = finish_cnt; d0 = drop_cnt; a0 = abort_cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_dout_valid: got %b expected 0", dout_valid); end
    if (bank_full !== 2'b00) begin errors++; $display("FAIL rst_mid_bank_full: got %b expected 00", bank_full); end
    if (finish_cnt - f0 + drop_cnt - d0 + abort_cnt - a0 !== 0) begin
      errors++;
      $display("FAIL rst_mid_pulses: got %0d pulses expected 0", finish_cnt - f0 + drop_cnt - d0 + abort_cnt - a0);
    end
`ifdef PCD_FRAME_STATS_EN
    checks += 2;
    if (frames_done !== 16'd0)    begin errors++; $display("FAIL rst_mid_frames_done: got %0d expected 0", frames_done); end
    if (frames_dropped !== 16'd0) begin errors++; $display("FAIL rst_mid_frames_dropped: got %0d expected 0", frames_dropped); end
`endif
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    f0 = finish_cnt;
    send_frame(170, FRAME_LEN, 1, 1);
    wait_drain("rst_mid");
    checks += 2;
    if (finish_cnt - f0 !== 1) begin errors++; $display("FAIL rst_mid_finish_count: got %0d expected 1", finish_cnt - f0); end
    if (bank_full !== 2'b00)   begin errors++; $display("FAIL rst_mid_bank_full_end: got %b expected 00", bank_full); end
  endtask

  initial begin
    reset       = 1'b1;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    symbol_din  = '0;
    dout_ready  = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_abort();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
